// File: rtl/multi_chan_delay_line.sv
// multi_chan_delay_line: per-channel programmable cycle delay, transport (exact history)
// or inertial (passes only values held stable for the configured number of samples).
module multi_chan_delay_line #(
    parameter int CHANNELS = 2,
    parameter int WIDTH = 2,
    parameter int MAX_DELAY = 16,
    parameter int DEFAULT_DELAY = 1,
    localparam int DW = $clog2(MAX_DELAY + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      cfg_load,
    input  logic [CHANNELS*DW-1:0]    cfg_delay,
    input  logic [CHANNELS-1:0]       cfg_mode,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid
);
    localparam int AW = $clog2(MAX_DELAY);
    localparam logic [DW-1:0] ONE = DW'(1);
    localparam logic [DW-1:0] MAXD = DW'(MAX_DELAY);
    localparam logic [DW-1:0] DEFD = DW'(DEFAULT_DELAY);
    localparam logic [DW:0] MAXW = (DW + 1)'(MAX_DELAY);

    logic [AW-1:0] wp_q, wp_d;
    logic [DW-1:0] fill_q, fill_d;

    always_comb begin
        wp_d = wp_q == AW'(MAX_DELAY - 1) ? '0 : wp_q + 1'b1;
        fill_d = fill_q == MAXD ? fill_q : fill_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q <= '0;
            fill_q <= '0;
        end else begin
            wp_q <= wp_d;
            fill_q <= fill_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DW-1:0] req, delay_q, delay_d, cnt_q, cnt_d;
        logic mode_q, mode_d, valid_q, valid_d;
        logic [WIDTH-1:0] smp, prev_q, out_q, out_d;
        logic [WIDTH-1:0] mem_q [MAX_DELAY];
        logic [DW:0] rd_raw;
        logic [AW-1:0] rd;

        assign smp = in_data[c*WIDTH +: WIDTH];
        assign req = cfg_delay[c*DW +: DW];

        // A freshly loaded config already governs the read made at its own load edge.
        always_comb begin
            delay_d = !cfg_load ? delay_q : req == '0 ? ONE : req > MAXD ? MAXD : req;
            mode_d = cfg_load ? cfg_mode[c] : mode_q;
            cnt_d = (mode_d != mode_q || smp != prev_q) ? ONE :
                    cnt_q >= delay_d ? delay_d : cnt_q + ONE;
            rd_raw = (DW + 1)'(wp_q) + MAXW - {1'b0, delay_d};
            rd = AW'(rd_raw >= MAXW ? rd_raw - MAXW : rd_raw);
            out_d = mode_d ? (cnt_d == delay_d ? smp : out_q) : mem_q[rd];
            valid_d = fill_d >= delay_d;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                delay_q <= DEFD;
                mode_q <= 1'b0;
                cnt_q <= '0;
                prev_q <= '0;
                out_q <= '0;
                valid_q <= 1'b0;
            end else begin
                delay_q <= delay_d;
                mode_q <= mode_d;
                cnt_q <= cnt_d;
                prev_q <= smp;
                out_q <= out_d;
                valid_q <= valid_d;
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n) mem_q[wp_q] <= smp;
        end

        assign out_data[c*WIDTH +: WIDTH] = out_q;
        assign out_valid[c] = valid_q;
    end
endmodule

// File: tb/tb_multi_chan_delay_line.sv
// tb_multi_chan_delay_line: directed scenarios plus random traffic against a
// history-array reference model of the delay line.
module tb_multi_chan_delay_line;
    localparam int CH = 2;
    localparam int W = 8;
    localparam int MD = 16;
    localparam int DD = 1;
    localparam int DW = $clog2(MD + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_load = 1'b0;
    logic [CH*W-1:0] in_data = '0;
    logic [CH*DW-1:0] cfg_delay = '0;
    logic [CH-1:0] cfg_mode = '0;
    logic [CH*W-1:0] out_data;
    logic [CH-1:0] out_valid;

    int checks = 0;
    int errors = 0;

    int n;
    int m_d [CH];
    bit m_mode [CH];
    int m_cnt [CH];
    logic [W-1:0] m_prev [CH];
    logic [W-1:0] m_out [CH];
    bit m_known [CH];
    bit m_valid [CH];
    logic [W-1:0] hist [CH][8192];

    multi_chan_delay_line #(.CHANNELS(CH), .WIDTH(W), .MAX_DELAY(MD), .DEFAULT_DELAY(DD)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .cfg_load(cfg_load),
        .cfg_delay(cfg_delay), .cfg_mode(cfg_mode), .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one edge, advance the reference model, then compare every known output.
    task automatic step(input logic r, input logic ld, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [CH-1:0] md, input logic [W-1:0] i0, input logic [W-1:0] i1);
        logic [W-1:0] s;
        int req;
        bit chg;
        rst_n = r;
        cfg_load = ld;
        cfg_delay = {d1, d0};
        cfg_mode = md;
        in_data = {i1, i0};
        @(posedge clk);
        if (!r) begin
            n = 0;
            for (int c = 0; c < CH; c++) begin
                m_d[c] = DD;
                m_mode[c] = 1'b0;
                m_cnt[c] = 0;
                m_prev[c] = '0;
                m_out[c] = '0;
                m_known[c] = 1'b1;
                m_valid[c] = 1'b0;
            end
        end else begin
            n++;
            for (int c = 0; c < CH; c++) begin
                s = c == 0 ? i0 : i1;
                req = c == 0 ? int'(d0) : int'(d1);
                chg = 1'b0;
                if (ld) begin
                    chg = md[c] != m_mode[c];
                    m_d[c] = req == 0 ? 1 : (req > MD ? MD : req);
                    m_mode[c] = md[c];
                end
                hist[c][n] = s;
                m_cnt[c] = (chg || s != m_prev[c]) ? 1 : (m_cnt[c] + 1 > m_d[c] ? m_d[c] : m_cnt[c] + 1);
                m_prev[c] = s;
                if (m_mode[c]) begin
                    if (m_cnt[c] == m_d[c]) begin
                        m_out[c] = s;
                        m_known[c] = 1'b1;
                    end
                end else if (n > m_d[c]) begin
                    m_out[c] = hist[c][n - m_d[c]];
                    m_known[c] = 1'b1;
                end else begin
                    m_known[c] = 1'b0;
                end
                m_valid[c] = (n > MD ? MD : n) >= m_d[c];
            end
        end
        #1;
        for (int c = 0; c < CH; c++) begin
            check($sformatf("valid%0d", c), 32'(out_valid[c]), 32'(m_valid[c]));
            if (m_known[c]) check($sformatf("data%0d", c), 32'(out_data[c*W +: W]), 32'(m_out[c]));
        end
    endtask

    task automatic tick(input logic [W-1:0] i0, input logic [W-1:0] i1);
        step(1'b1, 1'b0, '0, '0, cfg_mode, i0, i1);
    endtask

    task automatic load(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [CH-1:0] md,
                        input logic [W-1:0] i0, input logic [W-1:0] i1);
        step(1'b1, 1'b1, d0, d1, md, i0, i1);
    endtask

    task automatic reset();
        step(1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [W-1:0] drv [64];
        logic [W-1:0] a, b;
        reset();
        reset();
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);

        load(5'd3, 5'd1, 2'b00, 8'd1, 8'd0);
        tick(8'd2, 8'd0);
        check("t1_valid_e2", 32'(out_valid[0]), 32'h0);
        tick(8'd3, 8'd0);
        check("t1_valid_e3", 32'(out_valid[0]), 32'h1);
        tick(8'd0, 8'd0);
        check("t1_out_e4", 32'(out_data[7:0]), 32'd1);
        tick(8'd0, 8'd0);
        check("t1_out_e5", 32'(out_data[7:0]), 32'd2);
        tick(8'd0, 8'd0);
        check("t1_out_e6", 32'(out_data[7:0]), 32'd3);

        load(5'd3, 5'd4, 2'b10, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick(8'd0, i < 2 ? 8'd1 : 8'd0);
            check("t2_glitch", 32'(out_data[15:8]), 32'd0);
        end
        for (int i = 1; i <= 5; i++) begin
            tick(8'd0, 8'd1);
            check($sformatf("t2_hold%0d", i), 32'(out_data[15:8]), i >= 4 ? 32'd1 : 32'd0);
        end

        reset();
        load(5'd0, 5'd1, 2'b00, 8'h11, 8'h00);
        check("t3_zero_valid", 32'(out_valid[0]), 32'h1);
        tick(8'h22, 8'h00);
        check("t3_zero_out", 32'(out_data[7:0]), 32'h11);
        reset();
        load(5'd21, 5'd1, 2'b00, 8'h00, 8'h00);
        for (int i = 2; i <= 16; i++) begin
            tick(8'($urandom), 8'($urandom));
            if (i == 15) check("t3_max_valid15", 32'(out_valid[0]), 32'h0);
        end
        check("t3_max_valid16", 32'(out_valid[0]), 32'h1);

        load(5'd8, 5'd1, 2'b00, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) begin
            drv[i] = 8'($urandom);
            tick(drv[i], 8'h00);
        end
        drv[12] = 8'($urandom);
        load(5'd2, 5'd1, 2'b00, drv[12], 8'h00);
        check("t4_shrink_valid", 32'(out_valid[0]), 32'h1);
        check("t4_shrink_out", 32'(out_data[7:0]), 32'(drv[10]));
        reset();
        load(5'd2, 5'd1, 2'b00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) tick(8'($urandom), 8'($urandom));
        load(5'd8, 5'd1, 2'b00, 8'h00, 8'h00);
        check("t4_grow_drop", 32'(out_valid[0]), 32'h0);
        tick(8'h00, 8'h00);
        check("t4_grow_e7", 32'(out_valid[0]), 32'h0);
        tick(8'h00, 8'h00);
        check("t4_grow_e8", 32'(out_valid[0]), 32'h1);

        load(5'd5, 5'd7, 2'b01, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) tick(8'($urandom), 8'($urandom));
        step(1'b0, 1'b1, 5'd9, 5'd9, 2'b11, 8'hff, 8'hff);
        check("t5_rst_data", 32'(out_data), 32'h0);
        check("t5_rst_valid", 32'(out_valid), 32'h0);
        tick(8'h5a, 8'ha5);
        check("t5_default_valid", 32'(out_valid), 32'h3);

        reset();
        load(5'd16, 5'd16, 2'b00, 8'd1, 8'd1);
        for (int j = 2; j <= 3 * MD; j++) begin
            tick(8'(j), 8'(j));
            if (j > MD) check("t6_wrap", 32'(out_data[7:0]), 32'(8'(j - MD)));
        end

        a = '0;
        b = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(2) == 0) a = 8'($urandom_range(3));
            if ($urandom_range(2) == 0) b = 8'($urandom_range(3));
            if ($urandom_range(99) == 0) reset();
            else if ($urandom_range(9) == 0)
                load(5'($urandom_range(31)), 5'($urandom_range(31)), 2'($urandom_range(3)), a, b);
            else tick(a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
